// File: rtl/timer_irq_ctrl_pkg.sv
// ============================================================================
// Module  : timer_irq_ctrl_pkg
// Brief   : Register map, field indices and FSM states for timer_irq_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package timer_irq_ctrl_pkg;

    localparam logic [3:0] TIM_COUNT  = 4'h0;
    localparam logic [3:0] TIM_PERIOD = 4'h4;
    localparam logic [3:0] TIM_CTRL   = 4'h8;
    localparam logic [3:0] TIM_STATUS = 4'hC;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;

    localparam int STAT_PEND = 0;
    localparam int STAT_OVR  = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } tim_state_t;

    function automatic logic [1:0] word_idx(input logic [3:0] off);
        return off[3:2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_irq_ctrl.sv
// ============================================================================
// Module  : timer_irq_ctrl
// Brief   : Memory-mapped compare/interrupt unit on the ms Timer count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_irq_ctrl
    import timer_irq_ctrl_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [CNT_W-1:0]  Do,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WE,
    input  logic [CNT_W-1:0]  Din,
    output logic [CNT_W-1:0]  Dout,
    output logic              IRQ
);

    tim_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_period, w_period_next;
    logic [CNT_W-1:0] r_target, w_target_next;
    logic [CNT_W-1:0] r_prev_cnt;
    logic             r_en, w_en_next;
    logic             r_periodic, w_periodic_next;
    logic             r_ie, w_ie_next;
    logic             r_pend, w_pend_next;
    logic             r_ovr, w_ovr_next;
    logic             r_irq, w_irq_next;

    logic [1:0]       w_word;
    logic             w_wr_period, w_wr_ctrl, w_wr_status;
    logic [CNT_W-1:0] w_eff;
    logic             w_tick, w_restart, w_fire;
    logic [1:0]       unused_addr_lsb;

    assign w_word          = Addr[3:2];
    assign unused_addr_lsb = Addr[1:0];

    assign w_wr_period = WE && (w_word == word_idx(TIM_PERIOD));
    assign w_wr_ctrl   = WE && (w_word == word_idx(TIM_CTRL));
    assign w_wr_status = WE && (w_word == word_idx(TIM_STATUS));

    assign w_eff  = (r_period == '0) ? CNT_W'(1) : r_period;
    assign w_tick = (Do != r_prev_cnt);

    // A backward step other than the natural 0xFF..F -> 0 wrap means the Timer restarted.
    assign w_restart = w_tick && (Do < r_prev_cnt) && (Do != r_prev_cnt + CNT_W'(1));

    assign w_fire = (r_state == ARMED) && w_tick && !w_restart && !w_wr_ctrl
                    && (Do == r_target);

    always_comb begin
        w_state_next    = r_state;
        w_period_next   = r_period;
        w_target_next   = r_target;
        w_en_next       = r_en;
        w_periodic_next = r_periodic;
        w_ie_next       = r_ie;
        w_pend_next     = r_pend;
        w_ovr_next      = r_ovr;

        if (w_wr_period) begin
            w_period_next = Din;
        end

        if (w_wr_ctrl) begin
            w_en_next       = Din[CTRL_EN];
            w_periodic_next = Din[CTRL_PERIODIC];
            w_ie_next       = Din[CTRL_IE];
            if (Din[CTRL_EN]) begin
                w_state_next  = ARMED;
                w_target_next = Do + w_eff;
            end else begin
                w_state_next  = IDLE;
            end
        end else if ((r_state == ARMED) && w_restart) begin
            w_target_next = Do + w_eff;
        end else if (w_fire) begin
            if (r_periodic) begin
                w_target_next = r_target + w_eff;
            end else begin
                w_en_next    = 1'b0;
                w_state_next = IDLE;
            end
        end

        if (w_wr_status) begin
            w_pend_next = r_pend & ~Din[STAT_PEND];
            w_ovr_next  = r_ovr  & ~Din[STAT_OVR];
        end
        // Setting wins over a same-cycle write-1-to-clear.
        if (w_fire) begin
            w_pend_next = 1'b1;
            if (r_pend) begin
                w_ovr_next = 1'b1;
            end
        end

        w_irq_next = w_pend_next & w_ie_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_period   <= '0;
            r_target   <= '0;
            r_prev_cnt <= '0;
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_ie       <= 1'b0;
            r_pend     <= 1'b0;
            r_ovr      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_period   <= w_period_next;
            r_target   <= w_target_next;
            r_prev_cnt <= Do;
            r_en       <= w_en_next;
            r_periodic <= w_periodic_next;
            r_ie       <= w_ie_next;
            r_pend     <= w_pend_next;
            r_ovr      <= w_ovr_next;
            r_irq      <= w_irq_next;
        end
    end

    always_comb begin
        Dout = '0;
        case (w_word)
            word_idx(TIM_COUNT):  Dout = Do;
            word_idx(TIM_PERIOD): Dout = r_period;
            word_idx(TIM_CTRL):   Dout = {{(CNT_W-3){1'b0}}, r_ie, r_periodic, r_en};
            default:              Dout = {{(CNT_W-2){1'b0}}, r_ovr, r_pend};
        endcase
    end

    assign IRQ = r_irq;

endmodule

`default_nettype wire
